// File: rtl/com_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : com_rx_fifo_pkg
// Shared status-register bit positions and mode encodings for the RX FIFO.
// Rev    : 1.0
// ============================================================================
package com_rx_fifo_pkg;

   localparam int   C_AVAIL       = 0;
   localparam int   C_OVERRUN     = 1;
   localparam int   C_COUNT_LSB   = 8;
   localparam int   C_COUNT_W     = 8;

   localparam logic C_MODE_DATA   = 1'b0;
   localparam logic C_MODE_STATUS = 1'b1;

   localparam int   C_TIMEOUT_W   = 20;

endpackage
`default_nettype wire

// File: rtl/com_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module : com_fifo_mem
// DEPTH x 8 storage: synchronous write, asynchronous read, no reset.
// Rev    : 1.0
// ============================================================================
module com_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] r_mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/com_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : com_rx_fifo
// UART receive FIFO with data/status read port and level interrupt.
// Optional idle-timeout interrupt enabled by macro COM_RX_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module com_rx_fifo
   import com_rx_fifo_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int INT_LEVEL      = 1,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rxdReady_i,
   input  logic [7:0]  rxdData_i,
   input  logic        enable_i,
   input  logic        readEnable_i,
   input  logic        mode_i,
   output logic [31:0] dataLoad_o,
   output logic        int_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] r_head, r_tail;
   logic [CW-1:0] r_count, w_count_nxt;
   logic          r_overrun, w_overrun_nxt;
   logic          r_data_req_q, r_stat_req_q;
   logic          w_data_req, w_stat_req;
   logic          w_empty, w_full;
   logic          w_pop, w_push, w_drop;
   logic          w_int_nxt;
   logic [7:0]    w_head_byte;
   logic [8:0]    w_count9;
   logic [7:0]    w_count8;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_data_req = enable_i & readEnable_i & (mode_i == C_MODE_DATA);
   assign w_stat_req = enable_i & readEnable_i & (mode_i == C_MODE_STATUS);

   // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
   assign w_pop         = w_data_req & ~r_data_req_q & ~w_empty;
   assign w_push        = rxdReady_i & (~w_full | w_pop);
   assign w_drop        = rxdReady_i & ~w_push;
   assign w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
   assign w_overrun_nxt = w_drop | (r_overrun & ~(w_stat_req & ~r_stat_req_q));

`ifdef COM_RX_TIMEOUT_EN
   logic [C_TIMEOUT_W-1:0] r_to_cnt, w_to_cnt_nxt;
   logic                   r_to_flag, w_to_flag_nxt;

   always_comb begin
      w_to_cnt_nxt  = r_to_cnt;
      w_to_flag_nxt = r_to_flag;
      if (w_push | w_pop) begin
         w_to_cnt_nxt  = '0;
         w_to_flag_nxt = 1'b0;
      end else if (w_empty) begin
         w_to_cnt_nxt  = '0;
      end else if (r_to_cnt != C_TIMEOUT_W'(TIMEOUT_CYCLES)) begin
         w_to_cnt_nxt = r_to_cnt + 1'b1;
         if (w_to_cnt_nxt == C_TIMEOUT_W'(TIMEOUT_CYCLES)) begin
            w_to_flag_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt  <= '0;
         r_to_flag <= 1'b0;
      end else begin
         r_to_cnt  <= w_to_cnt_nxt;
         r_to_flag <= w_to_flag_nxt;
      end
   end

   assign w_int_nxt = (w_count_nxt >= CW'(INT_LEVEL)) | w_to_flag_nxt;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^C_TIMEOUT_W'(TIMEOUT_CYCLES);
   assign w_int_nxt        = (w_count_nxt >= CW'(INT_LEVEL));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_overrun    <= 1'b0;
         r_data_req_q <= 1'b0;
         r_stat_req_q <= 1'b0;
         int_o        <= 1'b0;
      end else begin
         if (w_push) r_tail <= r_tail + AW'(1);
         if (w_pop)  r_head <= r_head + AW'(1);
         r_count      <= w_count_nxt;
         r_overrun    <= w_overrun_nxt;
         r_data_req_q <= w_data_req;
         r_stat_req_q <= w_stat_req;
         int_o        <= w_int_nxt;
      end
   end

   com_fifo_mem #(
      .DEPTH   (DEPTH),
      .AW      (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_push),
      .wr_addr (r_tail),
      .wr_data (rxdData_i),
      .rd_addr (r_head),
      .rd_data (w_head_byte)
   );

   // A full 256-entry FIFO saturates the 8-bit count field at 8'hFF.
   assign w_count9 = 9'(r_count);
   assign w_count8 = w_count9[8] ? 8'hFF : w_count9[7:0];

   always_comb begin
      dataLoad_o = '0;
      if (mode_i == C_MODE_STATUS) begin
         dataLoad_o[C_COUNT_LSB +: C_COUNT_W] = w_count8;
         dataLoad_o[C_OVERRUN]                = r_overrun;
         dataLoad_o[C_AVAIL]                  = ~w_empty;
      end else if (!w_empty) begin
         dataLoad_o[7:0] = w_head_byte;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_com_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_com_rx_fifo
// Directed, table-driven bench for com_rx_fifo (DEPTH=16, INT_LEVEL=4).
// Rev    : 1.0
// ============================================================================
module tb_com_rx_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rxdReady_i;
   logic [7:0]  rxdData_i;
   logic        enable_i;
   logic        readEnable_i;
   logic        mode_i;
   logic [31:0] dataLoad_o;
   logic        int_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   com_rx_fifo #(
      .DEPTH          (16),
      .INT_LEVEL      (4),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rxdReady_i   (rxdReady_i),
      .rxdData_i    (rxdData_i),
      .enable_i     (enable_i),
      .readEnable_i (readEnable_i),
      .mode_i       (mode_i),
      .dataLoad_o   (dataLoad_o),
      .int_o        (int_o)
   );

   typedef struct {
      logic        rdy;
      logic [7:0]  data;
      logic        en;
      logic        rd;
      logic        mode;
      logic [31:0] exp_load;
      logic        exp_int;
   } vec_t;

   vec_t vt [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, sample 1 time unit after posedge; rxdReady is a strobe.
   task automatic cycle(input logic rdy, input logic [7:0] d, input logic en,
                        input logic rd, input logic md);
      @(negedge clk);
      rxdReady_i   = rdy;
      rxdData_i    = d;
      enable_i     = en;
      readEnable_i = rd;
      mode_i       = md;
      @(posedge clk);
      #1;
      rxdReady_i   = 1'b0;
   endtask

   task automatic peek(input logic md, output logic [31:0] v);
      #1;
      enable_i     = 1'b1;
      readEnable_i = 1'b0;
      mode_i       = md;
      #1;
      v = dataLoad_o;
   endtask

   task automatic pop_one();
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] v;
      int          rise;

      vt[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
      vt[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 32'h0000_0041, 1'b0};
      vt[2]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 32'h0000_0041, 1'b0};
      vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000_0042, 1'b0};
      vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0042, 1'b0};
      vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
      vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
      vt[7]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 32'h0000_0101, 1'b0};
      vt[8]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 32'h0000_0201, 1'b0};
      vt[9]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 32'h0000_0301, 1'b0};
      vt[10] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 32'h0000_0401, 1'b1};
      vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000_0002, 1'b0};
      vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0301, 1'b0};
      vt[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000_0003, 1'b0};
      vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 1'b0};
      vt[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 1'b0};
      vt[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 1'b0};
      vt[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
      vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0};

      rst_n        = 1'b0;
      rxdReady_i   = 1'b0;
      rxdData_i    = 8'h00;
      enable_i     = 1'b0;
      readEnable_i = 1'b0;
      mode_i       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_int", {31'h0, int_o}, 32'h0);
      peek(1'b1, v);
      chk("reset_status", v, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic push/pop and level interrupt table
      for (int i = 0; i < 19; i++) begin
         cycle(vt[i].rdy, vt[i].data, vt[i].en, vt[i].rd, vt[i].mode);
         chk($sformatf("vec%0d_load", i), dataLoad_o, vt[i].exp_load);
         chk($sformatf("vec%0d_int", i), {31'h0, int_o}, {31'h0, vt[i].exp_int});
      end

      // Overflow: 17 pushes into 16 entries
      for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      peek(1'b1, v);
      chk("ovf_status", v, 32'h0000_1003);
      chk("ovf_int", {31'h0, int_o}, 32'h1);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      chk("ovf_clear", dataLoad_o, 32'h0000_1001);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         peek(1'b0, v);
         chk($sformatf("ovf_pop%0d", i), v, 32'(i));
         pop_one();
      end
      peek(1'b1, v);
      chk("ovf_drained", v, 32'h0);

      // Held read request pops exactly once
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      peek(1'b1, v);
      chk("hold_status", v, 32'h0000_0201);
      peek(1'b0, v);
      chk("hold_head", v, 32'h0000_00A1);
      pop_one();
      pop_one();

      // Simultaneous push and pop at full, mid and empty
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      peek(1'b1, v);
      chk("same_full_status", v, 32'h0000_1001);
      peek(1'b0, v);
      chk("same_full_head", v, 32'h0000_0011);
      repeat (11) pop_one();
      cycle(1'b1, 8'hEF, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      peek(1'b1, v);
      chk("same_mid_status", v, 32'h0000_0501);
      repeat (5) pop_one();
      cycle(1'b1, 8'hF0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      peek(1'b1, v);
      chk("same_empty_status", v, 32'h0000_0101);
      peek(1'b0, v);
      chk("same_empty_data", v, 32'h0000_00F0);
      pop_one();

      // Asynchronous reset between edges with 7 bytes queued
      for (int i = 0; i < 7; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
      chk("pre_rst_int", {31'h0, int_o}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_int", {31'h0, int_o}, 32'h0);
      peek(1'b1, v);
      chk("async_rst_status", v, 32'h0);
      peek(1'b0, v);
      chk("async_rst_data", v, 32'h0);
      rst_n = 1'b1;
      cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      peek(1'b0, v);
      chk("post_rst_data", v, 32'h0000_005A);
      peek(1'b1, v);
      chk("post_rst_status", v, 32'h0000_0101);
      pop_one();

`ifdef COM_RX_TIMEOUT_EN
      // Idle timeout with a single byte below INT_LEVEL
      cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      chk("to_int_start", {31'h0, int_o}, 32'h0);
      rise = 0;
      for (int k = 1; k <= 150; k++) begin
         @(posedge clk);
         #1;
         if (int_o && rise == 0) rise = k;
      end
      chk("to_rise_cycle", 32'(rise), 32'd100);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("to_int_cleared", {31'h0, int_o}, 32'h0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`else
      rise = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
